// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with HI/LO registers.
// Operands are kept as magnitudes; signs are reapplied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state;
  logic [WIDTH-1:0] r, q, b;
  logic [CW-1:0] cnt;
  logic is_div, neg_a, neg_r, zero_div;
  logic s1, s2;
  logic [WIDTH-1:0] m1, m2, quot, remd;
  logic [WIDTH:0] msum, dsh, dtrial;
  logic [2*WIDTH-1:0] prod;
  // Multiply keeps {r,q} as the product shifting right; divide keeps {r,q} as remainder/quotient shifting left.
  always_comb begin
    s1 = ~op[0] & data1[WIDTH-1];
    s2 = ~op[0] & data2[WIDTH-1];
    m1 = s1 ? -data1 : data1;
    m2 = s2 ? -data2 : data2;
    msum = {1'b0, r} + (q[0] ? {1'b0, b} : '0);
    dsh = {r, q[WIDTH-1]};
    dtrial = dsh - {1'b0, b};
    prod = neg_a ? -{r, q} : {r, q};
    quot = neg_a ? -q : q;
    remd = neg_r ? -r : r;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      r <= '0;
      q <= '0;
      b <= '0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_a <= 1'b0;
      neg_r <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            if (op == 3'b100) hi <= data1;
            else if (op == 3'b101) lo <= data1;
            else if (!op[2]) begin
              b <= op[1] ? m2 : m1;
              q <= op[1] ? m1 : m2;
              r <= '0;
              is_div <= op[1];
              neg_a <= s1 ^ s2;
              neg_r <= s1;
              zero_div <= data2 == '0;
              cnt <= LOAD;
              div_by_zero <= 1'b0;
              busy <= 1'b1;
              state <= CALC;
            end
          end
          CALC: begin
            cnt <= cnt - ONE;
            if (is_div) begin
              r <= dtrial[WIDTH] ? dsh[WIDTH-1:0] : dtrial[WIDTH-1:0];
              q <= {q[WIDTH-2:0], ~dtrial[WIDTH]};
            end else begin
              r <= msum[WIDTH:1];
              q <= {msum[0], q[WIDTH-1:1]};
            end
            if (cnt == ONE) state <= FIX;
          end
          FIX: begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            if (!is_div) {hi, lo} <= prod;
            else if (zero_div) div_by_zero <= 1'b1;
            else begin
              lo <= quot;
              hi <= remd;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
